// File: rtl/pipeline_stage_fifo.sv
// Elastic pipeline stage: a DEPTH-entry circular buffer with valid/stall handshakes
// on both sides, a hold input that pins the head, and a flush that empties the stage.
module pipeline_stage_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prev_done,
    output logic                   stall_prev,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   next_stall,
    output logic                   done_next,
    output logic [DATA_WIDTH-1:0]  data_out,
    input  logic                   hold,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]   head_r;
    logic [PTR_WIDTH-1:0]   tail_r;
    logic [COUNT_WIDTH-1:0] count_r;

    logic [PTR_WIDTH-1:0]   head_nxt_s;
    logic [PTR_WIDTH-1:0]   tail_nxt_s;
    logic [COUNT_WIDTH-1:0] count_nxt_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   done_s;
    logic                   stall_s;
    logic                   push_s;
    logic                   pop_s;

    // Explicit wrap keeps non-power-of-2 depths from walking past the last slot.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        logic [PTR_WIDTH-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_WIDTH{1'b0}};
        end else begin
            nxt = ptr + PTR_WIDTH'(1);
        end
        return nxt;
    endfunction

    // Handshake decode; a pop in a full cycle frees the slot for a same-cycle push.
    always_comb begin
        empty_s = (count_r == {COUNT_WIDTH{1'b0}});
        full_s  = (count_r == FULL_COUNT);
        done_s  = rst && !empty_s && !hold && !flush;
        pop_s   = done_s && !next_stall;
        stall_s = !rst || flush || (full_s && !pop_s);
        push_s  = prev_done && !stall_s;
    end

    // Next pointers and occupancy; flush zeroes everything.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            head_nxt_s  = {PTR_WIDTH{1'b0}};
            tail_nxt_s  = {PTR_WIDTH{1'b0}};
            count_nxt_s = {COUNT_WIDTH{1'b0}};
        end else begin
            if (pop_s) begin
                head_nxt_s = ptr_inc(head_r);
            end else begin
                head_nxt_s = head_r;
            end
            if (push_s) begin
                tail_nxt_s = ptr_inc(tail_r);
            end else begin
                tail_nxt_s = tail_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + COUNT_WIDTH'(1);
                2'b01:   count_nxt_s = count_r - COUNT_WIDTH'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PTR_WIDTH{1'b0}};
            tail_r  <= {PTR_WIDTH{1'b0}};
            count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Payload storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= data_in;
        end
    end

    assign data_out   = mem_r[head_r];
    assign done_next  = done_s;
    assign stall_prev = stall_s;
    assign count      = count_r;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: doc/pipeline_stage_fifo.md
PIPELINE_STAGE_FIFO -- requirements
Module: pipeline_stage_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits; legal range 1 and up.
REQ-002 Parameter DEPTH, default 2: number of entries; legal range 1 and up; DEPTH=1 gives a single-slot stage.
REQ-003 Localparam COUNT_WIDTH = $clog2(DEPTH+1): occupancy counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-006 prev_done  input  1  previous stage offers data_in this cycle.
REQ-007 stall_prev  output  1  block refuses data_in this cycle.
REQ-008 data_in  input  DATA_WIDTH  payload from previous stage.
REQ-009 next_stall  input  1  next stage refuses data_out this cycle.
REQ-010 done_next  output  1  block offers data_out this cycle.
REQ-011 data_out  output  DATA_WIDTH  oldest stored payload (head).
REQ-012 hold  input  1  head not yet consumable (e.g. operand contention); suppresses done_next.
REQ-013 flush  input  1  discard all stored entries (control-flow redirect).
REQ-014 count  output  COUNT_WIDTH  current number of valid entries.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.

Function
REQ-017 The block SHALL define transfer_prev = prev_done && !stall_prev and transfer_next = done_next && !next_stall; a payload moves only on a transfer.
REQ-018 The block SHALL store entries in a DEPTH-entry circular buffer with head/tail pointers that wrap from DEPTH-1 to 0, for power-of-2 and non-power-of-2 DEPTH alike.
REQ-019 The block SHALL drive done_next = rst && !empty && !hold && !flush.
REQ-020 The block SHALL drive stall_prev = !rst || flush || (full && !transfer_next); when full, a same-cycle pop SHALL free the slot for a same-cycle push.
REQ-021 data_out SHALL equal the head entry whenever !empty; when empty, its value is unspecified and consumers SHALL ignore it.
REQ-022 Latency: an entry accepted at edge N SHALL be offerable from the cycle after edge N; no combinational bypass from data_in to data_out.
REQ-023 Order: entries SHALL leave in acceptance order; none duplicated, none dropped except by flush or reset.
REQ-024 Count update per edge: +1 on push only, -1 on pop only, unchanged on push with pop or on neither; count SHALL never exceed DEPTH or drop below 0.
REQ-025 Flush high at an edge: count, head and tail SHALL become 0; no push and no pop SHALL occur that cycle (REQ-019 and REQ-020 guarantee this).
REQ-026 Hold high with !empty: the head SHALL stay in place; pushes SHALL continue until full.
REQ-027 Payload storage SHALL NOT need reset; only pointers and count are reset.

Reset
REQ-028 While rst=0, asynchronously: count=0, head=0, tail=0, empty=1, full=0 (full=1 never for DEPTH>=1), done_next=0, stall_prev=1.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; the first push is accepted at the first rising edge after rst returns to 1.

Verification
REQ-030 DEPTH=2, WIDTH=8: push 0x11, 0x22 with next_stall=1 -> full=1, stall_prev=1, count=2; drop next_stall -> pops 0x11 then 0x22 on consecutive cycles.
REQ-031 DEPTH=2 full, prev_done=1 with 0x33, next_stall=0 -> same edge pops 0x11 and pushes 0x33; count stays 2; next head 0x22.
REQ-032 DEPTH=3: stream 10 values 0x01..0x0A with random next_stall -> output order exact, pointers wrap, count stays within 0..3.
REQ-033 count=2, flush=1 for one cycle with prev_done=1 -> done_next=0 and stall_prev=1 that cycle; next cycle count=0, empty=1; 0x44 then pushes and is the next output.
REQ-034 hold=1 with head 0x55 and DEPTH=2 -> done_next=0; second push accepted, then stall_prev=1; release hold -> 0x55 pops first.
REQ-035 rst driven low between edges with count=1 -> count=0, done_next=0, stall_prev=1 immediately, without waiting for a clock edge; release -> empty=1.
